// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit: compare-mode encodings,
// FSM state type, BHT reset value and the operand-requirement helper.
package bru_pkg;

    // Compare modes carried in id_op; 3'b110 and 3'b111 are reserved.
    localparam logic [2:0] BRU_BEQ  = 3'b000;
    localparam logic [2:0] BRU_BNE  = 3'b001;
    localparam logic [2:0] BRU_BGTZ = 3'b010;
    localparam logic [2:0] BRU_BLEZ = 3'b011;
    localparam logic [2:0] BRU_BLTZ = 3'b100;
    localparam logic [2:0] BRU_BGEZ = 3'b101;

    // Weakly not-taken.
    localparam logic [1:0] BHT_INIT = 2'b01;

    typedef enum logic {
        StIdle,
        StWait
    } bru_state_e;

    // Only the two-operand compares wait on the rt forward.
    function automatic logic needs_rt(input logic [2:0] op);
        return (op == BRU_BEQ) || (op == BRU_BNE);
    endfunction

endpackage

// File: rtl/bru_bht.sv
// Branch history table: 2-bit saturating counters with an asynchronous
// prediction read port and a synchronous update port. The read port sees the
// pre-update value when both ports hit the same entry in one cycle.
module bru_bht
    import bru_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] cnt_q [DEPTH];
    logic [1:0] wr_cur;

    assign wr_cur   = cnt_q[wr_idx];
    assign rd_taken = cnt_q[rd_idx][1];

    // Counter array: synchronous reset to weakly not-taken, saturating update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= BHT_INIT;
            end
        end else if (wr_en) begin
            if (wr_taken) begin
                if (wr_cur != 2'b11) cnt_q[wr_idx] <= wr_cur + 2'd1;
            end else begin
                if (wr_cur != 2'b00) cnt_q[wr_idx] <= wr_cur - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: signed compare on forwarded ID operands, ID stall while
// operands are pending, BHT lookup from IF and a registered redirect on
// mispredict. Optional statistics counters are built when BRU_STATS_EN is defined.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   if_pc,
    output logic              if_pred_taken,
    input  logic              id_valid,
    input  logic              id_branch,
    input  logic [2:0]        id_op,
    input  logic [PC_W-1:0]   id_pc,
    input  logic [PC_W-1:0]   id_target,
    input  logic              id_pred_taken,
    input  logic [DATA_W-1:0] id_rs,
    input  logic [DATA_W-1:0] id_rt,
    input  logic              id_rs_rdy,
    input  logic              id_rt_rdy,
    output logic              id_stall,
    output logic              redirect,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              res_taken,
    output logic              res_valid
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]       stat_br,
    output logic [31:0]       stat_mis
`endif
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic              req;
    logic              ready;
    logic              resolve;
    logic              cmp_taken;
    logic              taken;
    logic              op_known;
    logic [PC_W-1:0]   next_pc;
    logic signed [DATA_W-1:0] rs_s;
    logic signed [DATA_W-1:0] rt_s;
    bru_state_e        state_q;

    // Only the index bits of the PCs reach the BHT; the rest are don't-care here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc, id_pc};

    assign req      = id_valid & id_branch;
    assign ready    = id_rs_rdy & (needs_rt(id_op) ? id_rt_rdy : 1'b1);
    assign resolve  = req & ready;
    assign id_stall = rst_n & req & ~ready;
    assign op_known = (id_op <= BRU_BGEZ);
    assign taken    = resolve & cmp_taken;
    assign next_pc  = taken ? id_target : (id_pc + PC_W'(4));
    assign rs_s     = $signed(id_rs);
    assign rt_s     = $signed(id_rt);

    // Signed compare; reserved modes resolve not-taken.
    always_comb begin
        cmp_taken = 1'b0;
        case (id_op)
            BRU_BEQ:  cmp_taken = (rs_s == rt_s);
            BRU_BNE:  cmp_taken = (rs_s != rt_s);
            BRU_BGTZ: cmp_taken = (rs_s > 0);
            BRU_BLEZ: cmp_taken = (rs_s <= 0);
            BRU_BLTZ: cmp_taken = (rs_s < 0);
            BRU_BGEZ: cmp_taken = (rs_s >= 0);
            default:  cmp_taken = 1'b0;
        endcase
    end

    bru_bht #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (if_pc[IDX_W+1:2]),
        .rd_taken (if_pred_taken),
        .wr_en    (resolve & op_known),
        .wr_idx   (id_pc[IDX_W+1:2]),
        .wr_taken (taken)
    );

    // Stall FSM plus the one-cycle resolve outputs, cleared on non-resolve cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            res_valid   <= 1'b0;
            res_taken   <= 1'b0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            case (state_q)
                StIdle: state_q <= (req && !ready) ? StWait : StIdle;
                StWait: begin
                    // A dropped request or a resolve both leave WAIT.
                    if (!req || ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
            res_valid   <= resolve;
            res_taken   <= taken;
            redirect    <= resolve & (taken != id_pred_taken);
            redirect_pc <= resolve ? next_pc : '0;
        end
    end

`ifdef BRU_STATS_EN
    // Saturating counts of resolved branches and redirects.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_br  <= '0;
            stat_mis <= '0;
        end else begin
            if (resolve && stat_br != 32'hFFFF_FFFF) stat_br <= stat_br + 32'd1;
            if (resolve && (taken != id_pred_taken) && stat_mis != 32'hFFFF_FFFF) begin
                stat_mis <= stat_mis + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus random
// traffic compared against a behavioural model every cycle.
module tb_branch_resolve_unit;

    localparam int DATA_W    = 32;
    localparam int PC_W      = 32;
    localparam int BHT_DEPTH = 64;
    localparam int IDX_W     = $clog2(BHT_DEPTH);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [PC_W-1:0]   if_pc;
    logic              if_pred_taken;
    logic              id_valid, id_branch, id_pred_taken, id_rs_rdy, id_rt_rdy;
    logic [2:0]        id_op;
    logic [PC_W-1:0]   id_pc, id_target;
    logic [DATA_W-1:0] id_rs, id_rt;
    logic              id_stall, redirect, res_taken, res_valid;
    logic [PC_W-1:0]   redirect_pc;
`ifdef BRU_STATS_EN
    logic [31:0]       stat_br, stat_mis;
`endif

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .DATA_W    (DATA_W),
        .PC_W      (PC_W),
        .BHT_DEPTH (BHT_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .id_valid      (id_valid),
        .id_branch     (id_branch),
        .id_op         (id_op),
        .id_pc         (id_pc),
        .id_target     (id_target),
        .id_pred_taken (id_pred_taken),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rs_rdy     (id_rs_rdy),
        .id_rt_rdy     (id_rt_rdy),
        .id_stall      (id_stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .res_taken     (res_taken),
        .res_valid     (res_valid)
`ifdef BRU_STATS_EN
        ,
        .stat_br       (stat_br),
        .stat_mis      (stat_mis)
`endif
    );

    int checks = 0;
    int errors = 0;
    int nres   = 0;

    // Model state: counter per BHT entry and the outputs expected after the next edge.
    int              mbht [BHT_DEPTH];
    logic            e_rv, e_rt, e_rd;
    logic [PC_W-1:0] e_rpc;
    longint          e_br, e_mis;

    function automatic logic ref_taken(input logic [2:0] op, input logic [31:0] rs,
                                       input logic [31:0] rt);
        int a, b;
        a = $signed(rs);
        b = $signed(rt);
        case (op)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd2: return a > 0;
            3'd3: return a <= 0;
            3'd4: return a < 0;
            3'd5: return a >= 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called just after inputs change (at a negedge); compares, advances the model,
    // then returns at the following negedge.
    task automatic run_cycle();
        logic req, rdy, res, tk;
        int   wi;
        #1;
        req = id_valid & id_branch;
        rdy = id_rs_rdy & ((id_op == 3'd0 || id_op == 3'd1) ? id_rt_rdy : 1'b1);
        chk("id_stall", id_stall, rst_n & req & ~rdy);
        chk("if_pred_taken", if_pred_taken, mbht[if_pc[IDX_W+1:2]] >= 2);
        chk("res_valid", res_valid, e_rv);
        chk("res_taken", res_taken, e_rt);
        chk("redirect", redirect, e_rd);
        chk("redirect_pc", redirect_pc, e_rpc);
`ifdef BRU_STATS_EN
        chk("stat_br", stat_br, e_br);
        chk("stat_mis", stat_mis, e_mis);
`endif
        if (!rst_n) begin
            e_rv = 0; e_rt = 0; e_rd = 0; e_rpc = '0; e_br = 0; e_mis = 0;
            for (int i = 0; i < BHT_DEPTH; i++) mbht[i] = 1;
        end else begin
            res   = req & rdy;
            tk    = res & ref_taken(id_op, id_rs, id_rt);
            e_rv  = res;
            e_rt  = tk;
            e_rd  = res & (tk != id_pred_taken);
            e_rpc = res ? (tk ? id_target : id_pc + 32'd4) : '0;
            if (res) begin
                nres++;
                if (e_br < 64'hFFFF_FFFF) e_br++;
                if (e_rd && e_mis < 64'hFFFF_FFFF) e_mis++;
                if (id_op <= 3'd5) begin
                    wi = int'(id_pc[IDX_W+1:2]);
                    if (tk && mbht[wi] < 3) mbht[wi]++;
                    else if (!tk && mbht[wi] > 0) mbht[wi]--;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic set_br(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic rs_rdy, input logic rt_rdy, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic pred);
        id_valid = 1; id_branch = 1; id_op = op; id_rs = rs; id_rt = rt;
        id_rs_rdy = rs_rdy; id_rt_rdy = rt_rdy; id_pc = pc; id_target = tgt;
        id_pred_taken = pred;
    endtask

    task automatic idle_in();
        id_valid = 0; id_branch = 0; id_op = 0; id_rs = 0; id_rt = 0;
        id_rs_rdy = 0; id_rt_rdy = 0; id_pc = 0; id_target = 0; id_pred_taken = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_in();
        run_cycle();
        rst_n = 1;
    endtask

    initial begin
        int n0;
        e_rv = 0; e_rt = 0; e_rd = 0; e_rpc = '0; e_br = 0; e_mis = 0;
        for (int i = 0; i < BHT_DEPTH; i++) mbht[i] = 1;
        if_pc = '0;
        rst_n = 0;
        idle_in();
        @(negedge clk);
        run_cycle();
        run_cycle();
        rst_n = 1;
        #1 chk("reset_res_valid", res_valid, 1'b0);
        chk("reset_redirect", redirect, 1'b0);

        // BEQ equal operands, predicted not-taken: taken mispredict.
        set_br(3'd0, 32'd5, 32'd5, 1, 1, 32'h40, 32'h200, 0);
        run_cycle();
        chk("t1_res_valid", res_valid, 1'b1);
        chk("t1_res_taken", res_taken, 1'b1);
        chk("t1_redirect", redirect, 1'b1);
        chk("t1_redirect_pc", redirect_pc, 32'h200);

        // BGTZ on -1 with rt not ready: no stall, not taken, correct prediction.
        set_br(3'd2, 32'hFFFF_FFFF, 32'd0, 1, 0, 32'h80, 32'h300, 0);
        #1 chk("t2_no_stall", id_stall, 1'b0);
        run_cycle();
        chk("t2_res_valid", res_valid, 1'b1);
        chk("t2_res_taken", res_taken, 1'b0);
        chk("t2_redirect", redirect, 1'b0);
        chk("t2_redirect_pc", redirect_pc, 32'h84);

        // BNE with rs pending for three cycles; resolves exactly once.
        n0 = nres;
        set_br(3'd1, 32'd1, 32'd2, 0, 1, 32'hC0, 32'h400, 1);
        for (int i = 0; i < 3; i++) begin
            #1 chk("t3_stall", id_stall, 1'b1);
            run_cycle();
            chk("t3_no_res", res_valid, 1'b0);
        end
        id_rs_rdy = 1;
        #1 chk("t3_release", id_stall, 1'b0);
        run_cycle();
        chk("t3_res_valid", res_valid, 1'b1);
        chk("t3_res_taken", res_taken, 1'b1);
        chk("t3_redirect", redirect, 1'b0);
        idle_in();
        run_cycle();
        chk("t3_single", res_valid, 1'b0);
        chk("t3_count", nres - n0, 1);

        // BHT entry 0 (pc 0x100) walks 01,10,11,11 then back down; reads are pre-write.
        do_reset();
        if_pc = 32'h100;
        for (int i = 0; i < 4; i++) begin
            set_br(3'd0, 32'd7, 32'd7, 1, 1, 32'h100, 32'h500, 0);
            #1 chk("t4_read_up", if_pred_taken, (i == 0) ? 1'b0 : 1'b1);
            run_cycle();
        end
        chk("t4_model_sat", mbht[0], 3);
        for (int i = 0; i < 2; i++) begin
            set_br(3'd1, 32'd7, 32'd7, 1, 1, 32'h100, 32'h500, 1);
            #1 chk("t4_read_down", if_pred_taken, 1'b1);
            run_cycle();
        end
        idle_in();
        #1 chk("t4_read_low", if_pred_taken, 1'b0);
        chk("t4_model_low", mbht[0], 1);
        run_cycle();

        // Train entry 16 taken, then reset while stalled in WAIT.
        set_br(3'd0, 32'd3, 32'd3, 1, 1, 32'h40, 32'h600, 1);
        run_cycle();
        idle_in();
        if_pc = 32'h40;
        #1 chk("t5_trained", if_pred_taken, 1'b1);
        run_cycle();
        set_br(3'd0, 32'd1, 32'd1, 0, 1, 32'h140, 32'h700, 0);
        #1 chk("t5_wait", id_stall, 1'b1);
        run_cycle();
        rst_n = 0;
        #1 chk("t5_stall_in_reset", id_stall, 1'b0);
        run_cycle();
        rst_n = 1;
        idle_in();
        #1 chk("t5_no_res", res_valid, 1'b0);
        chk("t5_bht_init", if_pred_taken, 1'b0);
        run_cycle();

`ifdef BRU_STATS_EN
        do_reset();
        set_br(3'd0, 32'd1, 32'd1, 1, 1, 32'h10, 32'h20, 1);
        run_cycle();
        set_br(3'd4, 32'd1, 32'd0, 1, 0, 32'h14, 32'h20, 0);
        run_cycle();
        set_br(3'd5, 32'd1, 32'd0, 1, 0, 32'h18, 32'h20, 0);
        run_cycle();
        idle_in();
        #1 chk("t6_stat_br", stat_br, 32'd3);
        chk("t6_stat_mis", stat_mis, 32'd1);
        run_cycle();
`endif

        // Random traffic with aliasing PCs and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pick;
            rst_n     = ($urandom_range(0, 63) != 0);
            id_valid  = ($urandom_range(0, 3) != 0);
            id_branch = ($urandom_range(0, 3) != 0);
            id_op     = 3'($urandom_range(0, 7));
            pick      = $urandom;
            case ($urandom_range(0, 3))
                0: id_rs = 32'd0;
                1: id_rs = 32'hFFFF_FFFF;
                2: id_rs = 32'($urandom_range(0, 3));
                default: id_rs = pick;
            endcase
            id_rt         = ($urandom_range(0, 1) != 0) ? id_rs : $urandom;
            id_rs_rdy     = ($urandom_range(0, 3) != 0);
            id_rt_rdy     = ($urandom_range(0, 3) != 0);
            id_pc         = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            id_target     = $urandom;
            id_pred_taken = 1'($urandom_range(0, 1));
            if_pc         = ($urandom_range(0, 2) == 0) ? id_pc
                                                         : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
